// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle ARM-subset control unit.
//   - FSM state encodings (exposed on state_dbg)
//   - ALUControl command codes (ARM data-processing cmd field)
//   - condition code values
//   - ResultSrc / ALUSrcB select values and Op class values
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_EOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_RSB = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_CMP = 4'b1010;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] RS_ALUOUT    = 2'b00;
    localparam logic [1:0] RS_READDATA  = 2'b01;
    localparam logic [1:0] RS_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_cond_unit.sv
// cond_unit: NZCV flag register plus condition evaluation.
//   clk, reset    : clock, synchronous active-high reset (clears flags)
//   i_cond        : instruction condition field
//   i_alu_flags   : live ALU {N,Z,C,V}
//   i_flag_w      : flag load request from the FSM (before condition gating)
//   o_cond_ex     : condition passes against the registered flags
//   o_flags       : registered {N,Z,C,V}
module cond_unit
    import ctrl_pkg::*;
#(
    parameter int FLAGW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       i_cond,
    input  logic [FLAGW-1:0] i_alu_flags,
    input  logic             i_flag_w,
    output logic             o_cond_ex,
    output logic [FLAGW-1:0] o_flags
);

    logic [FLAGW-1:0] r_flags;
    logic             w_n, w_z, w_c, w_v;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        case (i_cond)
            COND_EQ: o_cond_ex = w_z;
            COND_NE: o_cond_ex = ~w_z;
            COND_CS: o_cond_ex = w_c;
            COND_CC: o_cond_ex = ~w_c;
            COND_MI: o_cond_ex = w_n;
            COND_PL: o_cond_ex = ~w_n;
            COND_VS: o_cond_ex = w_v;
            COND_VC: o_cond_ex = ~w_v;
            COND_HI: o_cond_ex = w_c & ~w_z;
            COND_LS: o_cond_ex = ~w_c | w_z;
            COND_GE: o_cond_ex = (w_n == w_v);
            COND_LT: o_cond_ex = (w_n != w_v);
            COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: o_cond_ex = w_z | (w_n != w_v);
            COND_AL: o_cond_ex = 1'b1;
            default: o_cond_ex = 1'b0;   // 1111: never
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= '0;
        else if (i_flag_w && o_cond_ex)
            r_flags <= i_alu_flags;
    end

    assign o_flags = r_flags;

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-FSM control unit for the multicycle ARM-subset
// datapath (shared ALU, unified memory).
//   clk, reset     : clock, synchronous active-high reset
//   Cond/Op/Funct/Rd : instruction register fields
//   ALUFlags       : live ALU {N,Z,C,V}
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite : datapath enables/selects
//   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc : datapath muxes
//   Flags          : registered NZCV
//   state_dbg      : current FSM state
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int FLAGW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [1:0]       Op,
    input  logic [5:0]       Funct,
    input  logic [3:0]       Rd,
    input  logic [FLAGW-1:0] ALUFlags,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUControl,
    output logic [1:0]       ImmSrc,
    output logic [1:0]       RegSrc,
    output logic [FLAGW-1:0] Flags,
    output logic [3:0]       state_dbg
);

    state_t r_state;
    state_t w_next_state;

    logic w_cond_ex;
    logic w_no_write;     // TST/TEQ/CMP/CMN: flags only, no register result
    logic w_flag_w;
    logic w_pcw_fetch;    // PC+4 in FETCH, never condition-gated
    logic w_pcw_cond;     // branch / PC-destination write, condition-gated
    logic w_memw;
    logic w_regw;
    logic w_irw;

    assign w_no_write = (Op == OP_DP) && (Funct[4:3] == 2'b10);
    assign w_flag_w   = ((r_state == S_EXECUTER) || (r_state == S_EXECUTEI)) &&
                        (Funct[0] || w_no_write);

    cond_unit #(.FLAGW(FLAGW)) u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (Cond),
        .i_alu_flags (ALUFlags),
        .i_flag_w    (w_flag_w),
        .o_cond_ex   (w_cond_ex),
        .o_flags     (Flags)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next_state;
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_DP:   w_next_state = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_MEM:  w_next_state = S_MEMADR;
                    OP_BR:   w_next_state = S_BRANCH;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next_state = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            default:    w_next_state = S_FETCH;
        endcase
    end

    // Moore output decode (raw enables; condition/reset gating below)
    always_comb begin
        w_pcw_fetch = 1'b0;
        w_pcw_cond  = 1'b0;
        w_memw      = 1'b0;
        w_regw      = 1'b0;
        w_irw       = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RS_ALUOUT;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_RD2;
        ALUControl  = ALU_AND;
        case (r_state)
            S_FETCH: begin
                w_irw       = 1'b1;
                w_pcw_fetch = 1'b1;
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                ALUControl  = ALU_ADD;
                ResultSrc   = RS_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RS_ALURESULT;
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc  = RS_READDATA;
                w_regw     = 1'b1;
                w_pcw_cond = (Rd == 4'hF);
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                w_memw = 1'b1;
            end
            S_EXECUTER: ALUControl = Funct[4:1];
            S_EXECUTEI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = Funct[4:1];
            end
            S_ALUWB: begin
                w_regw     = ~w_no_write;
                w_pcw_cond = ~w_no_write && (Rd == 4'hF);
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                ResultSrc  = RS_ALURESULT;
                w_pcw_cond = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset forces every architectural write low so an aborted instruction
    // leaves no partial update behind.
    assign PCWrite  = ~reset & (w_pcw_fetch | (w_pcw_cond & w_cond_ex));
    assign MemWrite = ~reset & w_memw & w_cond_ex;
    assign RegWrite = ~reset & w_regw & w_cond_ex;
    assign IRWrite  = ~reset & w_irw;

    assign ImmSrc    = Op;
    assign RegSrc    = {(Op == OP_MEM) && !Funct[0], (Op == OP_BR)};
    assign state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0] ALUControl, Flags, state_dbg;

    multicycle_ctrl #(.FLAGW(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MW = 4, MWR = 5, XR = 6, XI = 7, WB = 8, BR = 9;

    int         m_state = FE;
    int         m_path[$];        // states still to visit before returning to FETCH
    logic [3:0] m_flags = 4'h0;
    bit         chk_en  = 1'b0;

    // Condition pass: each pair of codes is a base test and its inverse.
    function automatic logic cex(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, b;
        {n, z, cc, v} = f;
        if (c == 4'hE) return 1'b1;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0:    b = z;
            3'd1:    b = cc;
            3'd2:    b = n;
            3'd3:    b = v;
            3'd4:    b = cc & ~z;
            3'd5:    b = (n == v);
            default: b = ~z & (n == v);
        endcase
        return b ^ c[0];
    endfunction

    logic       e_pcw, e_adr, e_memw, e_irw, e_regw, e_srca;
    logic [1:0] e_rs, e_srcb;
    logic [3:0] e_aluc;
    logic       ce, nw;
    int         n_state;

    always begin
        @(negedge clk);
        ce = cex(Cond, m_flags);
        nw = (Op == 2'b00) && (Funct[4:3] == 2'b10);
        {e_pcw, e_adr, e_memw, e_irw, e_regw, e_srca} = '0;
        e_rs = 2'b00; e_srcb = 2'b00; e_aluc = 4'b0000;
        case (m_state)
            FE:  begin e_irw = 1; e_srca = 1; e_srcb = 2; e_aluc = 4'b0100; e_rs = 2; e_pcw = 1; end
            DE:  begin e_srca = 1; e_srcb = 2; e_aluc = 4'b0100; e_rs = 2; end
            MA:  begin e_srcb = 1; e_aluc = 4'b0100; end
            MR:  e_adr = 1;
            MW:  begin e_rs = 1; e_regw = ce; e_pcw = ce && Rd == 15; end
            MWR: begin e_adr = 1; e_memw = ce; end
            XR:  e_aluc = Funct[4:1];
            XI:  begin e_srcb = 1; e_aluc = Funct[4:1]; end
            WB:  begin e_regw = ce && !nw; e_pcw = ce && !nw && Rd == 15; end
            BR:  begin e_srcb = 1; e_aluc = 4'b0100; e_rs = 2; e_pcw = ce; end
            default: ;
        endcase
        if (reset) {e_pcw, e_memw, e_regw, e_irw} = '0;
        if (chk_en) begin
            chk("PCWrite",    PCWrite,    e_pcw);
            chk("AdrSrc",     AdrSrc,     e_adr);
            chk("MemWrite",   MemWrite,   e_memw);
            chk("IRWrite",    IRWrite,    e_irw);
            chk("RegWrite",   RegWrite,   e_regw);
            chk("ResultSrc",  ResultSrc,  e_rs);
            chk("ALUSrcA",    ALUSrcA,    e_srca);
            chk("ALUSrcB",    ALUSrcB,    e_srcb);
            chk("ALUControl", ALUControl, e_aluc);
            chk("ImmSrc",     ImmSrc,     Op);
            chk("RegSrc",     RegSrc,     {Op == 2'b01 && !Funct[0], Op == 2'b10});
            chk("Flags",      Flags,      m_flags);
            chk("state_dbg",  state_dbg,  m_state);
        end
        // advance the model over the coming edge
        if (reset) begin
            m_path.delete();
            n_state = FE;
        end else begin
            if ((m_state == XR || m_state == XI) && (Funct[0] || nw) && ce)
                m_flags = ALUFlags;
            if (m_state == DE) begin
                m_path.delete();
                case (Op)
                    2'b01: m_path = Funct[0] ? '{MA, MR, MW} : '{MA, MWR};
                    2'b00: m_path = '{Funct[5] ? XI : XR, WB};
                    2'b10: m_path = '{BR};
                    default: ;
                endcase
            end
            if (m_state == FE)         n_state = DE;
            else if (m_path.size() > 0) n_state = m_path.pop_front();
            else                        n_state = FE;
        end
        @(posedge clk);
        if (reset) m_flags = 4'h0;
        m_state = n_state;
    end

    // ---------------- stimulus ----------------
    logic [31:0] tw;
    logic [7:0]  mk_pcw, mk_regw, mk_memw;

    task automatic apply(input logic [31:0] ins, input logic [3:0] af);
        Cond = ins[31:28]; Op = ins[27:26]; Funct = ins[25:20]; Rd = ins[15:12];
        ALUFlags = af;
    endtask

    task automatic sample();
        tw      = {tw[27:0], state_dbg};
        mk_pcw  = {mk_pcw[6:0], PCWrite};
        mk_regw = {mk_regw[6:0], RegWrite};
        mk_memw = {mk_memw[6:0], MemWrite};
    endtask

    // Called at posedge+2 with the DUT in FETCH; returns there after the instruction.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af);
        bit done;
        done = 0;
        apply(ins, af);
        tw = '0; mk_pcw = '0; mk_regw = '0; mk_memw = '0;
        #1 sample();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #2;
            if (state_dbg == 4'd0) begin done = 1; break; end
            #1 sample();
        end
        if (!done) chk("instr_return_to_fetch", 32'd0, 32'd1);
    endtask

    logic [31:0] rins;
    logic [3:0]  rc;
    bit          got;

    initial begin
        reset = 1'b1;
        apply(32'hF000_0000 | (32'h3 << 26), 4'h0);
        @(posedge clk); #2 chk_en = 1'b1;
        @(posedge clk); @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("rst_state", state_dbg, 4'd0);
        chk("rst_flags", Flags, 4'h0);

        run_instr(32'hE082_1003, 4'hF);          // ADD R1,R2,R3
        chk("add_states", tw, 32'h0168);
        chk("add_regw",   mk_regw, 8'b0001);
        chk("add_pcw",    mk_pcw,  8'b1000);
        chk("add_flags",  Flags, 4'h0);

        run_instr(32'hE250_0001, 4'b0100);       // SUBS R0,R0,#1
        chk("subs_states", tw, 32'h0178);
        chk("subs_flags",  Flags, 4'b0100);

        run_instr(32'h0A00_0002, 4'h0);          // BEQ, taken
        chk("beq_states", tw, 32'h019);
        chk("beq_pcw",    mk_pcw, 8'b101);

        run_instr(32'h1A00_0002, 4'h0);          // BNE with Z=1, not taken
        chk("bne_states", tw, 32'h019);
        chk("bne_pcw",    mk_pcw, 8'b100);

        run_instr(32'hE595_4008, 4'h0);          // LDR R4,[R5,#8]
        chk("ldr_states", tw, 32'h01234);
        chk("ldr_regw",   mk_regw, 8'b00001);

        run_instr(32'hE585_4008, 4'h0);          // STR R4,[R5,#8]
        chk("str_states", tw, 32'h0125);
        chk("str_memw",   mk_memw, 8'b0001);
        chk("str_regw",   mk_regw, 8'b0000);
        chk("str_regsrc", RegSrc, 2'b10);

        run_instr(32'hE351_0000, 4'b0010);       // CMP R1,#0
        chk("cmp_states", tw, 32'h0178);
        chk("cmp_regw",   mk_regw, 8'b0000);
        chk("cmp_flags",  Flags, 4'b0010);

        run_instr(32'hE1A0_F002, 4'h0);          // MOV PC,R2
        chk("movpc_pcw",  mk_pcw,  8'b1001);
        chk("movpc_regw", mk_regw, 8'b0001);

        // Reset held 3 cycles from mid-MEMWRITE
        apply(32'hE585_4008, 4'h0);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            if (state_dbg == 4'd5) begin got = 1; break; end
        end
        chk("reach_memwrite", got, 1'b1);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("rst_memw", MemWrite, 1'b0);
            @(posedge clk); #2;
        end
        reset = 1'b0;
        #1;
        chk("rel_state", state_dbg, 4'd0);
        chk("rel_flags", Flags, 4'h0);
        chk("rel_irw",   IRWrite, 1'b1);
        chk("rel_pcw",   PCWrite, 1'b1);
        #1;

        // Randomised instruction stream, checked every cycle by the model
        for (int i = 0; i < 400; i++) begin
            rins = $urandom;
            rc   = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rins[31:28] = rc;
            if ($urandom_range(0, 7) == 0) rins[15:12] = 4'hF;
            if (rins[27:26] == 2'b00 && rins[24:23] == 2'b10 && rins[15:12] == 4'hF)
                rins[15:12] = 4'h0;
            run_instr(rins, 4'($urandom_range(0, 15)));
        end

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Control unit for the multicycle version of the 32-bit ARM-subset datapath, which shares one ALU and one unified memory across cycles. Decodes Cond/Op/Funct/Rd from the instruction register, sequences each instruction through a Moore FSM, and drives all datapath enables and selects. Holds the NZCV flag register and gates every architectural write with the condition check.

Parameters:
FLAGW, 4, flag register width (NZCV; fixed, no other value supported)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
Cond  in  4  Instr[31:28]
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]
Rd  in  4  Instr[15:12]
ALUFlags  in  4  live ALU {N,Z,C,V}
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write enable
IRWrite  out  1  instruction register enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
ALUSrcA  out  1  0=RD1, 1=PC
ALUSrcB  out  2  00=shifted RD2, 01=ExtImm, 10=constant 4
ALUControl  out  4  ALU op
ImmSrc  out  2  extender select
RegSrc  out  2  RA1/RA2 mux selects
Flags  out  4  registered NZCV
state_dbg  out  4  current FSM state

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are illegal and go to FETCH.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 with Funct[5]=0->EXECUTER, with Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH (NOP).
  - MEMADR: Funct[0]=1->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH. MEMWRITE->FETCH.
  - EXECUTER/EXECUTEI->ALUWB->FETCH. BRANCH->FETCH.
- Latency: DP 4 cycles, LDR 5, STR 4, B 3.
- Outputs are a Moore decode of state. Anything not listed below is 0.
  - FETCH: IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10 (forms PC+8).
  - MEMADR: ALUSrcB=01, ADD.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite.
  - MEMWRITE: AdrSrc=1, MemWrite.
  - EXECUTER: ALUSrcB=00, ALUControl=Funct[4:1].
  - EXECUTEI: ALUSrcB=01, ALUControl=Funct[4:1].
  - ALUWB: ResultSrc=00, RegWrite.
  - BRANCH: ALUSrcB=01, ADD, ResultSrc=10, PCWrite.
- ALUControl encodings follow ARM cmd: AND=0000, EOR=0001, SUB=0010, RSB=0011, ADD=0100, ORR=1100, MOV=1101, CMP=1010.
- ImmSrc = Op, in every state.
- RegSrc[0] = (Op==10). RegSrc[1] = (Op==01 && Funct[0]==0).
- CondEx is combinational from Cond and the Flags register:
  - Codes EQ..LE follow the ARM definitions.
  - AL (1110) gives 1. 1111 gives 0.
- Gating by CondEx:
  - Applies to MemWrite, RegWrite, the BRANCH PCWrite, and flag update.
  - The FETCH PCWrite and IRWrite are never gated.
  - A failed condition still walks the full state path, with writes suppressed.
- NoWrite: for DP with Funct[4:1] in 1000..1011 (TST/TEQ/CMP/CMN), RegWrite is 0 in ALUWB.
- PC as destination: Rd=15 in ALUWB or MEMWB asserts PCWrite (gated by CondEx) in addition to RegWrite.
- Flag update:
  - At the clock edge ending EXECUTER/EXECUTEI, Flags <= ALUFlags.
  - Requires (Funct[0]==1 or NoWrite) and CondEx.
  - All four flags are loaded.
- Reset:
  - State <= FETCH and Flags <= 0000 on the next edge.
  - While reset is high, PCWrite, MemWrite, RegWrite and IRWrite are forced to 0.
  - Reset asserted mid-instruction aborts it. No partial write occurs in the reset cycle.
  - First post-reset cycle is FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings
  - ALUControl constants
  - condition code constants
  - ResultSrc/ALUSrcB select constants
- Sub-module cond_unit holds the Flags register, CondEx evaluation and the flag-write enable.
- FSM and output decode stay in multicycle_ctrl.

Test Plan:
1. Reset held 3 cycles mid-MEMWRITE -> MemWrite=0 throughout; state_dbg=0 and Flags=0000 after release; first cycle asserts IRWrite=1 and PCWrite=1.
2. ADD R1,R2,R3 (0xE0821003) -> states 0,1,6,8,0; ALUControl=0100 in EXECUTER; RegWrite=1 only in ALUWB; Flags unchanged.
3. SUBS R0,R0,#1 (0xE2500001) with ALUFlags=0100 -> state 7, ALUSrcB=01, ALUControl=0010; Flags=0100 after EXECUTEI; following BEQ 0x0A000002 -> BRANCH with PCWrite=1.
4. BNE 0x1A000002 with Z=1 -> BRANCH state entered, PCWrite=0; next state FETCH.
5. LDR R4,[R5,#8] (0xE5954008) -> states 0,1,2,3,4,0; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (0xE5854008) -> MEMWRITE with MemWrite=1, RegSrc=10.
6. CMP R1,#0 (0xE3510000) -> no RegWrite in ALUWB, Flags loaded. MOV PC,R2 (0xE1A0F002) -> PCWrite=1 in ALUWB.
